// File: rtl/issue_stage.sv
// issue_stage: one-entry hold register, RAW/capacity scoreboard, registered operand issue to execute.
// Define FWD_EN to let a same-cycle writeback clear the hazard and bypass wb_data into the operands.
module issue_stage #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int SB_W = 2
) (
   input  logic            clk,
   input  logic            nrst,
   input  logic            dec_valid,
   output logic            dec_ready,
   input  logic [4:0]      dec_rs1,
   input  logic [4:0]      dec_rs2,
   input  logic [4:0]      dec_rd,
   input  logic            dec_we,
   input  logic            dec_use_rs1,
   input  logic            dec_use_rs2,
   input  logic [XLEN-1:0] dec_imm,
   input  logic            dec_imm_sel,
   input  logic [2:0]      dec_fn,
   input  logic [3:0]      dec_alu_fn,
   input  logic [XLEN-1:0] dec_pc,
   input  logic            flush,
   input  logic            wb_we,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            iss_valid,
   output logic [XLEN-1:0] op_a,
   output logic [XLEN-1:0] op_b,
   output logic [4:0]      rd4,
   output logic            we4,
   output logic [2:0]      fn4,
   output logic [3:0]      alu_fn4,
   output logic [XLEN-1:0] pc4,
   output logic            stall
);

   localparam logic [SB_W-1:0] SB_MAX = {SB_W{1'b1}};
   localparam logic [SB_W-1:0] SB_ONE = SB_W'(1);

   logic            hv;
   logic [4:0]      h_rs1, h_rs2, h_rd;
   logic            h_we, h_use_rs1, h_use_rs2, h_imm_sel;
   logic [XLEN-1:0] h_imm, h_pc;
   logic [2:0]      h_fn;
   logic [3:0]      h_alu_fn;

   logic [XLEN-1:0] rf [NREG];
   logic [SB_W-1:0] sb [NREG];
   logic [NREG-1:0] sb_inc, sb_dec;

   logic [SB_W-1:0] sb_rs1, sb_rs2, sb_rd;
   logic            byp1, byp2, clr1, clr2;
   logic            haz1, haz2, haz_cap, hazard, fire;
   logic [XLEN-1:0] val1, val2;

   assign sb_rs1 = sb[h_rs1];
   assign sb_rs2 = sb[h_rs2];
   assign sb_rd  = sb[h_rd];

`ifdef FWD_EN
   assign byp1 = wb_we && (wb_rd == h_rs1) && (h_rs1 != 5'd0);
   assign byp2 = wb_we && (wb_rd == h_rs2) && (h_rs2 != 5'd0);
   // Only the last outstanding write may be bypassed; older ones would be stale.
   assign clr1 = byp1 && (sb_rs1 == SB_ONE);
   assign clr2 = byp2 && (sb_rs2 == SB_ONE);
`else
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
   assign clr1 = 1'b0;
   assign clr2 = 1'b0;
`endif

   assign haz1    = h_use_rs1 && (h_rs1 != 5'd0) && (sb_rs1 != '0) && !clr1;
   assign haz2    = h_use_rs2 && (h_rs2 != 5'd0) && (sb_rs2 != '0) && !clr2;
   assign haz_cap = h_we && (h_rd != 5'd0) && (sb_rd == SB_MAX);
   assign hazard  = haz1 || haz2 || haz_cap;

   assign fire      = hv && !flush && !hazard;
   assign stall     = hv && hazard;
   assign dec_ready = !hv || fire;

   assign val1 = (h_rs1 == 5'd0) ? '0 : (byp1 ? wb_data : rf[h_rs1]);
   assign val2 = (h_rs2 == 5'd0) ? '0 : (byp2 ? wb_data : rf[h_rs2]);

   always_comb begin
      sb_inc = '0;
      sb_dec = '0;
      if (fire && h_we && (h_rd != 5'd0))
         sb_inc[h_rd] = 1'b1;
      if (wb_we && (wb_rd != 5'd0) && (sb[wb_rd] != '0))
         sb_dec[wb_rd] = 1'b1;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         hv        <= 1'b0;
         h_rs1     <= '0;
         h_rs2     <= '0;
         h_rd      <= '0;
         h_we      <= 1'b0;
         h_use_rs1 <= 1'b0;
         h_use_rs2 <= 1'b0;
         h_imm     <= '0;
         h_imm_sel <= 1'b0;
         h_fn      <= '0;
         h_alu_fn  <= '0;
         h_pc      <= '0;
      end else if (dec_valid && dec_ready && !flush) begin
         hv        <= 1'b1;
         h_rs1     <= dec_rs1;
         h_rs2     <= dec_rs2;
         h_rd      <= dec_rd;
         h_we      <= dec_we;
         h_use_rs1 <= dec_use_rs1;
         h_use_rs2 <= dec_use_rs2;
         h_imm     <= dec_imm;
         h_imm_sel <= dec_imm_sel;
         h_fn      <= dec_fn;
         h_alu_fn  <= dec_alu_fn;
         h_pc      <= dec_pc;
      end else if (fire || flush) begin
         hv <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < NREG; i++) begin
            sb[i] <= '0;
            rf[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (sb_inc[i] && !sb_dec[i])
               sb[i] <= sb[i] + SB_ONE;
            else if (sb_dec[i] && !sb_inc[i])
               sb[i] <= sb[i] - SB_ONE;
         end
         if (wb_we && (wb_rd != 5'd0))
            rf[wb_rd] <= wb_data;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         iss_valid <= 1'b0;
         op_a      <= '0;
         op_b      <= '0;
         rd4       <= '0;
         we4       <= 1'b0;
         fn4       <= '0;
         alu_fn4   <= '0;
         pc4       <= '0;
      end else if (fire) begin
         iss_valid <= 1'b1;
         op_a      <= val1;
         op_b      <= h_imm_sel ? h_imm : val2;
         rd4       <= h_rd;
         we4       <= h_we;
         fn4       <= h_fn;
         alu_fn4   <= h_alu_fn;
         pc4       <= h_pc;
      end else begin
         iss_valid <= 1'b0;
         we4       <= 1'b0;
      end
   end

endmodule

// File: tb/tb_issue_stage.sv
// Directed bench for issue_stage; expectations follow FWD_EN when it is defined.
module tb_issue_stage;

   logic        clk = 1'b0;
   logic        nrst;
   logic        dec_valid, dec_ready;
   logic [4:0]  dec_rs1, dec_rs2, dec_rd;
   logic        dec_we, dec_use_rs1, dec_use_rs2, dec_imm_sel;
   logic [31:0] dec_imm, dec_pc;
   logic [2:0]  dec_fn;
   logic [3:0]  dec_alu_fn;
   logic        flush, wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        iss_valid, we4, stall;
   logic [31:0] op_a, op_b, pc4;
   logic [4:0]  rd4;
   logic [2:0]  fn4;
   logic [3:0]  alu_fn4;

   int n_tests = 0;
   int n_fail  = 0;

   issue_stage dut (
      .clk(clk), .nrst(nrst),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_we(dec_we),
      .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
      .dec_imm(dec_imm), .dec_imm_sel(dec_imm_sel),
      .dec_fn(dec_fn), .dec_alu_fn(dec_alu_fn), .dec_pc(dec_pc),
      .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .iss_valid(iss_valid), .op_a(op_a), .op_b(op_b), .rd4(rd4), .we4(we4),
      .fn4(fn4), .alu_fn4(alu_fn4), .pc4(pc4), .stall(stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic send(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic we, input logic u1, input logic u2,
                       input logic [31:0] imm, input logic isel, input logic [31:0] pc);
      dec_valid   = 1'b1;
      dec_rs1     = rs1;
      dec_rs2     = rs2;
      dec_rd      = rd;
      dec_we      = we;
      dec_use_rs1 = u1;
      dec_use_rs2 = u2;
      dec_imm     = imm;
      dec_imm_sel = isel;
      dec_pc      = pc;
      #1;
   endtask

   task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] d);
      wb_we   = en;
      wb_rd   = rd;
      wb_data = d;
      #1;
   endtask

   initial begin
      nrst = 1'b0;
      dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0; dec_we = 1'b0;
      dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0; dec_imm = '0; dec_imm_sel = 1'b0;
      dec_fn = 3'd3; dec_alu_fn = 4'd5; dec_pc = '0;
      flush = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
      tick(); tick();
      chk("rst_iss_valid", {31'd0, iss_valid}, 32'd0);
      chk("rst_op_a", op_a, 32'd0);
      chk("rst_pc4", pc4, 32'd0);
      chk("rst_we4", {31'd0, we4}, 32'd0);
      chk("rst_dec_ready", {31'd0, dec_ready}, 32'd1);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      nrst = 1'b1;

      // Basic issue from an all-zero register file.
      send(5'd5, 5'd6, 5'd1, 1'b0, 1'b1, 1'b1, 32'hAAAA, 1'b0, 32'h100);
      chk("t1_ready_empty", {31'd0, dec_ready}, 32'd1);
      tick(); dec_valid = 1'b0; #1;
      chk("t1_ready_fire", {31'd0, dec_ready}, 32'd1);
      chk("t1_stall", {31'd0, stall}, 32'd0);
      tick();
      chk("t1_iss_valid", {31'd0, iss_valid}, 32'd1);
      chk("t1_op_a", op_a, 32'd0);
      chk("t1_op_b", op_b, 32'd0);
      chk("t1_fn4", {29'd0, fn4}, 32'd3);
      chk("t1_alu_fn4", {28'd0, alu_fn4}, 32'd5);
      chk("t1_pc4", pc4, 32'h100);
      chk("t1_we4", {31'd0, we4}, 32'd0);
      tick();
      chk("t1_idle_valid", {31'd0, iss_valid}, 32'd0);
      chk("t1_idle_pc4_hold", pc4, 32'h100);

      // RAW on x3.
      send(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 32'h55, 1'b1, 32'h200);
      tick();
      send(5'd3, 5'd0, 5'd4, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h204);
      chk("t2_ready_b", {31'd0, dec_ready}, 32'd1);
      tick(); dec_valid = 1'b0; #1;
      chk("t2_a_valid", {31'd0, iss_valid}, 32'd1);
      chk("t2_a_rd4", {27'd0, rd4}, 32'd3);
      chk("t2_a_we4", {31'd0, we4}, 32'd1);
      chk("t2_a_imm", op_b, 32'h55);
      chk("t2_a_pc4", pc4, 32'h200);
      chk("t2_stall", {31'd0, stall}, 32'd1);
      chk("t2_ready_stall", {31'd0, dec_ready}, 32'd0);
      tick();
      chk("t2_bubble_valid", {31'd0, iss_valid}, 32'd0);
      chk("t2_bubble_we4", {31'd0, we4}, 32'd0);
      chk("t2_stall_hold", {31'd0, stall}, 32'd1);
      wb(1'b1, 5'd3, 32'h1234);
`ifdef FWD_EN
      chk("t2_stall_wb", {31'd0, stall}, 32'd0);
      tick(); wb(1'b0, 5'd0, 32'd0);
`else
      chk("t2_stall_wb", {31'd0, stall}, 32'd1);
      tick(); wb(1'b0, 5'd0, 32'd0);
      chk("t2_no_issue_yet", {31'd0, iss_valid}, 32'd0);
      chk("t2_stall_clear", {31'd0, stall}, 32'd0);
      tick();
`endif
      chk("t2_b_valid", {31'd0, iss_valid}, 32'd1);
      chk("t2_b_op_a", op_a, 32'h1234);
      chk("t2_b_op_b", op_b, 32'd0);
      chk("t2_b_pc4", pc4, 32'h204);

      // WAW up to the counter limit on x7.
      send(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h300); tick();
      send(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h304); tick();
      send(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h308); tick();
      send(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h30C); tick();
      dec_valid = 1'b0; #1;
      chk("t3_cap_stall", {31'd0, stall}, 32'd1);
      chk("t3_cap_ready", {31'd0, dec_ready}, 32'd0);
      chk("t3_third_pc4", pc4, 32'h308);
      tick();
      chk("t3_cap_bubble", {31'd0, iss_valid}, 32'd0);
      wb(1'b1, 5'd7, 32'h77);
      chk("t3_cap_wb_stall", {31'd0, stall}, 32'd1);
      tick(); wb(1'b0, 5'd0, 32'd0);
      chk("t3_cap_release", {31'd0, stall}, 32'd0);
      send(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h310);
      chk("t3_ready_fifth", {31'd0, dec_ready}, 32'd1);
      tick(); dec_valid = 1'b0; #1;
      chk("t3_fourth_valid", {31'd0, iss_valid}, 32'd1);
      chk("t3_fourth_pc4", pc4, 32'h30C);
      chk("t3_fourth_rd4", {27'd0, rd4}, 32'd7);
      chk("t3_sb_back_to_max", {31'd0, stall}, 32'd1);

      // Flush a held, hazarded instruction.
      flush = 1'b1; #1;
      chk("t4_flush_ready", {31'd0, dec_ready}, 32'd0);
      tick(); flush = 1'b0; #1;
      chk("t4_flush_stall", {31'd0, stall}, 32'd0);
      chk("t4_flush_valid", {31'd0, iss_valid}, 32'd0);
      chk("t4_flush_ready_after", {31'd0, dec_ready}, 32'd1);
      // Flush also kills an instruction offered in the same cycle.
      send(5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h3F0);
      flush = 1'b1;
      tick(); dec_valid = 1'b0; flush = 1'b0;
      tick();
      chk("t4_killed_valid", {31'd0, iss_valid}, 32'd0);
      chk("t4_killed_pc4", pc4, 32'h30C);
      send(5'd5, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'h400);
      tick(); dec_valid = 1'b0;
      tick();
      chk("t4_next_valid", {31'd0, iss_valid}, 32'd1);
      chk("t4_next_pc4", pc4, 32'h400);

      // Same-cycle increment and decrement of x9.
      send(5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h500); tick();
      send(5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h504); tick();
      dec_valid = 1'b0;
      wb(1'b1, 5'd9, 32'h9999);
      chk("t5_w2_fires", {31'd0, stall}, 32'd0);
      chk("t5_w1_pc4", pc4, 32'h500);
      tick(); wb(1'b0, 5'd0, 32'd0);
      chk("t5_w2_pc4", pc4, 32'h504);
      send(5'd9, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'h508);
      tick(); dec_valid = 1'b0; #1;
      chk("t5_sb_still_one", {31'd0, stall}, 32'd1);
      wb(1'b1, 5'd9, 32'hABCD);
`ifdef FWD_EN
      chk("t5_stall_wb", {31'd0, stall}, 32'd0);
      tick(); wb(1'b0, 5'd0, 32'd0);
`else
      chk("t5_stall_wb", {31'd0, stall}, 32'd1);
      tick(); wb(1'b0, 5'd0, 32'd0);
      chk("t5_stall_clear", {31'd0, stall}, 32'd0);
      tick();
`endif
      chk("t5_r_valid", {31'd0, iss_valid}, 32'd1);
      chk("t5_r_op_a", op_a, 32'hABCD);
      chk("t5_r_pc4", pc4, 32'h508);

      // Writes to x0 are dropped and never bypassed.
      wb(1'b1, 5'd0, 32'hFFFF_FFFF);
      send(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h700);
      tick(); dec_valid = 1'b0;
      tick(); wb(1'b0, 5'd0, 32'd0);
      chk("t6_x0_valid", {31'd0, iss_valid}, 32'd1);
      chk("t6_x0_op_a", op_a, 32'd0);
      chk("t6_x0_op_b", op_b, 32'd0);
      chk("t6_x0_pc4", pc4, 32'h700);

      // Asynchronous reset in the middle of a stall.
      send(5'd0, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h600); tick();
      send(5'd11, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'h604); tick();
      dec_valid = 1'b0; #1;
      chk("t7_pre_stall", {31'd0, stall}, 32'd1);
      chk("t7_pre_pc4", pc4, 32'h600);
      #1 nrst = 1'b0;
      #1;
      chk("t7_rst_valid", {31'd0, iss_valid}, 32'd0);
      chk("t7_rst_pc4", pc4, 32'd0);
      chk("t7_rst_we4", {31'd0, we4}, 32'd0);
      chk("t7_rst_rd4", {27'd0, rd4}, 32'd0);
      chk("t7_rst_stall", {31'd0, stall}, 32'd0);
      chk("t7_rst_ready", {31'd0, dec_ready}, 32'd1);
      tick(); nrst = 1'b1;
      send(5'd3, 5'd11, 5'd0, 1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 32'h608);
      tick(); dec_valid = 1'b0; #1;
      chk("t7_sb_cleared", {31'd0, stall}, 32'd0);
      tick();
      chk("t7_post_valid", {31'd0, iss_valid}, 32'd1);
      chk("t7_rf_cleared", op_a, 32'd0);
      chk("t7_post_op_b", op_b, 32'd0);
      chk("t7_post_pc4", pc4, 32'h608);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
